// File: rtl/mm_dma_engine_pkg.sv
// Shared types for the DMA engine: controller states, operation codes and word size.
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_FETCH,
        ST_WR_REQ,
        ST_DONE,
        ST_RELEASE
    } dma_state_t;

    typedef enum logic [1:0] {
        OP_LOAD_A,
        OP_LOAD_B,
        OP_STORE_C
    } dma_op_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mm_dma_addr_gen.sv
// Address generator: holds the latched base/length and the word index, produces the
// byte address of the current word and flags the final word of the transfer.
module mm_dma_addr_gen
    import mm_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LENGTH_W = 8,
    parameter int STEP     = WORD_BYTES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                inc,
    input  logic [ADDR_W-1:0]   new_base,
    input  logic [LENGTH_W-1:0] new_len,
    output logic [ADDR_W-1:0]   address,
    output logic [LENGTH_W-1:0] index,
    output logic                last
);

    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

    logic [ADDR_W-1:0]   base;
    logic [LENGTH_W-1:0] len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base  <= '0;
            len   <= '0;
            index <= '0;
        end else if (load) begin
            base  <= new_base;
            len   <= new_len;
            index <= '0;
        end else if (inc) begin
            index <= index + LENGTH_W'(1);
        end
    end

    // Address wraps naturally modulo 2^ADDR_W.
    assign address = base + (ADDR_W'(index) * STEP_A);
    assign last    = ((index + LENGTH_W'(1)) == len);

endmodule

// File: rtl/mm_dma_engine.sv
// Memory-mapped DMA engine: loads A/B operand buffers from memory and stores the C buffer.
// Build option MM_DMA_PERF_EN adds perf_cycles, a saturating count of busy cycles.
module mm_dma_engine
    import mm_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LENGTH_W = 8,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_load_a,
    input  logic                start_load_b,
    input  logic                start_store_c,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [ADDR_W-1:0]   addr_c,
    input  logic [LENGTH_W-1:0] len_a,
    input  logic [LENGTH_W-1:0] len_b,
    input  logic [LENGTH_W-1:0] len_c,
    output logic                done_load_a,
    output logic                done_load_b,
    output logic                done_store_c,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                buf_a_we,
    output logic                buf_b_we,
    output logic [LENGTH_W-1:0] buf_waddr,
    output logic [DATA_W-1:0]   buf_wdata,
    output logic [LENGTH_W-1:0] buf_c_raddr,
    input  logic [DATA_W-1:0]   buf_c_rdata,
    output logic                busy
`ifdef MM_DMA_PERF_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    dma_state_t          state;
    dma_state_t          next_state;
    dma_op_t             op;
    dma_op_t             sel_op;
    logic                sel_valid;
    logic [ADDR_W-1:0]   sel_base;
    logic [LENGTH_W-1:0] sel_len;
    logic                load;
    logic                inc;
    logic                last;
    logic [LENGTH_W-1:0] index;

    // Fixed-priority pick among the level requests: load_a, then load_b, then store_c.
    always_comb begin
        sel_valid = 1'b0;
        sel_op    = OP_LOAD_A;
        sel_base  = addr_a;
        sel_len   = len_a;
        if (start_load_a) begin
            sel_valid = 1'b1;
        end else if (start_load_b) begin
            sel_valid = 1'b1;
            sel_op    = OP_LOAD_B;
            sel_base  = addr_b;
            sel_len   = len_b;
        end else if (start_store_c) begin
            sel_valid = 1'b1;
            sel_op    = OP_STORE_C;
            sel_base  = addr_c;
            sel_len   = len_c;
        end
    end

    assign load = (state == ST_IDLE) && sel_valid;

    mm_dma_addr_gen #(
        .ADDR_W   (ADDR_W),
        .LENGTH_W (LENGTH_W),
        .STEP     (DATA_W / 8)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .inc      (inc),
        .new_base (sel_base),
        .new_len  (sel_len),
        .address  (avm_address),
        .index    (index),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op    <= OP_LOAD_A;
        end else begin
            state <= next_state;
            if (load) begin
                op <= sel_op;
            end
        end
    end

    always_comb begin
        next_state    = state;
        inc           = 1'b0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        buf_a_we      = 1'b0;
        buf_b_we      = 1'b0;
        buf_wdata     = '0;
        done_load_a   = 1'b0;
        done_load_b   = 1'b0;
        done_store_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    if (sel_len == '0) begin
                        next_state = ST_DONE;
                    end else if (sel_op == OP_STORE_C) begin
                        next_state = ST_WR_FETCH;
                    end else begin
                        next_state = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (avm_readdatavalid) begin
                    buf_a_we   = (op == OP_LOAD_A);
                    buf_b_we   = (op == OP_LOAD_B);
                    buf_wdata  = avm_readdata;
                    inc        = 1'b1;
                    next_state = last ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_WR_FETCH: begin
                next_state = ST_WR_REQ;
            end
            // buf_c_raddr stays on index, so the buffer's registered output holds through a stall.
            ST_WR_REQ: begin
                avm_write     = 1'b1;
                avm_writedata = buf_c_rdata;
                if (!avm_waitrequest) begin
                    inc        = 1'b1;
                    next_state = last ? ST_DONE : ST_WR_FETCH;
                end
            end
            ST_DONE: begin
                done_load_a  = (op == OP_LOAD_A);
                done_load_b  = (op == OP_LOAD_B);
                done_store_c = (op == OP_STORE_C);
                next_state   = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!start_load_a && !start_load_b && !start_store_c) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign buf_waddr   = index;
    assign buf_c_raddr = index;
    assign busy        = (state != ST_IDLE);

`ifdef MM_DMA_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
